// File: rtl/mem_chan_arb_pkg.sv
// mem_chan_pkg: shared encodings for the memory channel arbiter.
//   state_e  - channel FSM states (IDLE / ISSUE / WAIT)
//   owner_e  - requester identity (IF = fetch, LS = load-store)
//   IDX_W_DEF / IDX_LSB_DEF - default DDR word-index geometry
package mem_chan_pkg;

    localparam int IDX_W_DEF   = 19;
    localparam int IDX_LSB_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_chan_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant (fetch vs load-store).
//   clock, reset  - clock, async active-high reset
//   i_req_if      - fetch request (already qualified by the caller)
//   i_req_ls      - load-store request
//   i_accept      - a grant was taken this cycle; updates last-granted
//   o_gnt_vld     - some requester is granted
//   o_gnt_owner   - which requester is granted
// The grant itself is purely combinational; only the last-granted memory
// is registered. It resets to LS so fetch wins the first tie.
module rr_arb2
    import mem_chan_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   i_req_if,
    input  logic   i_req_ls,
    input  logic   i_accept,
    output logic   o_gnt_vld,
    output owner_e o_gnt_owner
);

    owner_e r_last;

    always_comb begin
        o_gnt_vld = i_req_if | i_req_ls;
        if (i_req_if && i_req_ls)
            o_gnt_owner = (r_last == OWN_IF) ? OWN_LS : OWN_IF;
        else if (i_req_ls)
            o_gnt_owner = OWN_LS;
        else
            o_gnt_owner = OWN_IF;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_last <= OWN_LS;
        else if (i_accept)
            r_last <= o_gnt_owner;
    end

endmodule

// File: rtl/mem_chan_arb.sv
// mem_chan_arb: shares one DDR command/response channel between the fetch
// unit and the load-store unit, one transaction outstanding at a time.
//   clock, reset                 - clock, async active-high reset
//   if_req_*/if_done/if_rdata    - fetch request handshake and completion
//   redirect_valid               - front-end redirect, kills an in-flight fetch
//   ls_req_*/ls_done/ls_rdata    - load-store request handshake and completion
//   ddr_req_*/ddr_index/we/...   - DDR command (held stable until accepted)
//   ddr_resp_valid/ddr_rdata     - DDR response (read data or write ack)
// Killed fetches still run to completion on the DDR side so the response is
// drained; only the if_done pulse is suppressed.
module mem_chan_arb
    import mem_chan_pkg::*;
#(
    parameter int IDX_W   = IDX_W_DEF,
    parameter int IDX_LSB = IDX_LSB_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_req_valid,
    input  logic [63:0]      if_req_addr,
    output logic             if_req_ready,
    output logic             if_done,
    output logic [63:0]      if_rdata,
    input  logic             redirect_valid,
    input  logic             ls_req_valid,
    output logic             ls_req_ready,
    input  logic [63:0]      ls_req_addr,
    input  logic             ls_req_we,
    input  logic [63:0]      ls_req_wdata,
    input  logic [7:0]       ls_req_wmask,
    output logic             ls_done,
    output logic [63:0]      ls_rdata,
    output logic             ddr_req_valid,
    input  logic             ddr_req_ready,
    output logic [IDX_W-1:0] ddr_index,
    output logic             ddr_we,
    output logic [63:0]      ddr_wdata,
    output logic [7:0]       ddr_wmask,
    input  logic             ddr_resp_valid,
    input  logic [63:0]      ddr_rdata
);

    state_e           r_state, w_state_nxt;
    owner_e           r_owner;
    logic [IDX_W-1:0] r_index;
    logic             r_we;
    logic [63:0]      r_wdata;
    logic [7:0]       r_wmask;
    logic             r_kill;
    logic             r_if_done, r_ls_done;
    logic [63:0]      r_if_rdata, r_ls_rdata;

    logic             w_if_eff;
    logic             w_gnt_vld;
    owner_e           w_gnt_owner;
    logic             w_accept;
    logic             w_resp;
    logic             w_kill_now;
    logic             w_unused;

    // A fetch presented alongside a redirect carries a stale address, so it
    // is hidden from the arbiter; LS may take the slot instead.
    assign w_if_eff = if_req_valid && !redirect_valid;

    rr_arb2 u_arb (
        .clock       (clock),
        .reset       (reset),
        .i_req_if    (w_if_eff),
        .i_req_ls    (ls_req_valid),
        .i_accept    (w_accept),
        .o_gnt_vld   (w_gnt_vld),
        .o_gnt_owner (w_gnt_owner)
    );

    // Ready is only ever raised toward a valid requester, so ready==handshake.
    assign w_accept = if_req_ready || ls_req_ready;
    assign w_resp   = (r_state == ST_WAIT) && ddr_resp_valid;

    // Include the current cycle's redirect so one arriving together with the
    // response still suppresses if_done.
    assign w_kill_now = r_kill ||
                        (redirect_valid && (r_owner == OWN_IF) && (r_state != ST_IDLE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        ddr_req_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld && !reset) begin
                    if_req_ready = (w_gnt_owner == OWN_IF);
                    ls_req_ready = (w_gnt_owner == OWN_LS);
                    w_state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ddr_req_valid = 1'b1;
                if (ddr_req_ready)
                    w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (ddr_resp_valid)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner    <= OWN_IF;
            r_index    <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_kill     <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
        end else begin
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;

            if (w_accept) begin
                r_owner <= w_gnt_owner;
                if (w_gnt_owner == OWN_IF) begin
                    r_index <= if_req_addr[IDX_LSB +: IDX_W];
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                    r_wmask <= 8'hFF;
                end else begin
                    r_index <= ls_req_addr[IDX_LSB +: IDX_W];
                    r_we    <= ls_req_we;
                    r_wdata <= ls_req_wdata;
                    r_wmask <= ls_req_wmask;
                end
            end

            if (w_resp) begin
                r_kill <= 1'b0;
                if (r_owner == OWN_IF) begin
                    r_if_done <= !w_kill_now;
                    if (!w_kill_now)
                        r_if_rdata <= ddr_rdata;
                end else begin
                    r_ls_done  <= 1'b1;
                    r_ls_rdata <= r_we ? 64'd0 : ddr_rdata;
                end
            end else if (r_state != ST_IDLE) begin
                r_kill <= w_kill_now;
            end
        end
    end

    assign ddr_index = r_index;
    assign ddr_we    = r_we;
    assign ddr_wdata = r_wdata;
    assign ddr_wmask = r_wmask;
    assign if_done   = r_if_done;
    assign if_rdata  = r_if_rdata;
    assign ls_done   = r_ls_done;
    assign ls_rdata  = r_ls_rdata;

    // Address bits outside the index window are intentionally dropped.
    assign w_unused = ^{if_req_addr, ls_req_addr};

endmodule

// File: tb/tb_mem_chan_arb.sv
module tb_mem_chan_arb;
    localparam int IDX_W   = 19;
    localparam int IDX_LSB = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             if_req_valid, if_req_ready, if_done, redirect_valid;
    logic [63:0]      if_req_addr, if_rdata;
    logic             ls_req_valid, ls_req_ready, ls_req_we, ls_done;
    logic [63:0]      ls_req_addr, ls_req_wdata, ls_rdata;
    logic [7:0]       ls_req_wmask;
    logic             ddr_req_valid, ddr_req_ready, ddr_we, ddr_resp_valid;
    logic [IDX_W-1:0] ddr_index;
    logic [63:0]      ddr_wdata, ddr_rdata;
    logic [7:0]       ddr_wmask;

    mem_chan_arb #(.IDX_W(IDX_W), .IDX_LSB(IDX_LSB)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_done(if_done), .if_rdata(if_rdata), .redirect_valid(redirect_valid),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_done(ls_done), .ls_rdata(ls_rdata),
        .ddr_req_valid(ddr_req_valid), .ddr_req_ready(ddr_req_ready), .ddr_index(ddr_index),
        .ddr_we(ddr_we), .ddr_wdata(ddr_wdata), .ddr_wmask(ddr_wmask),
        .ddr_resp_valid(ddr_resp_valid), .ddr_rdata(ddr_rdata)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0;

    // Transaction-level reference: one job in flight, split into
    // "command not yet accepted" and "awaiting response".
    bit               m_busy, m_pend, m_killed, m_last_ls, m_owner_ls, m_we;
    logic [IDX_W-1:0] m_idx;
    logic [63:0]      m_wdata;
    logic [7:0]       m_wmask;
    bit               e_if_done, e_ls_done;
    logic [63:0]      e_if_rdata, e_ls_rdata;
    int               grant_log[$];

    // Observations
    int               n_if_done_obs = 0, n_ls_done_obs = 0, n_ddr_hs = 0, n_ddr_vld = 0;
    logic [63:0]      last_if_rdata, last_ls_rdata;

    // DDR behaviour knobs
    int               ddr_mode = 0, hold_cyc = 0, resp_lat = 0, cnt_cmd = 0, cnt_wait = 0;
    bit               spur = 0;
    logic [63:0]      rdata_val = 64'd0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_pend = 0; m_killed = 0; m_last_ls = 1;
        e_if_done = 0; e_ls_done = 0;
    endtask

    task automatic drive_ddr();
        if (ddr_mode == 1) begin
            ddr_rdata      = {$urandom, $urandom};
            ddr_req_ready  = 1'($urandom_range(0, 1));
            ddr_resp_valid = (m_busy && !m_pend) ? ($urandom_range(0, 2) == 0)
                                                 : ($urandom_range(0, 7) == 0);
        end else begin
            ddr_rdata      = rdata_val;
            ddr_req_ready  = m_busy && m_pend && (cnt_cmd >= hold_cyc);
            ddr_resp_valid = (m_busy && !m_pend && (cnt_wait >= resp_lat)) || spur;
        end
    endtask

    // One clock: drive DDR side, compare mid-cycle, advance the model, step.
    task automatic cyc();
        bit f_eff, x_if, x_ls;
        drive_ddr();
        #4;
        f_eff = if_req_valid && !redirect_valid;
        x_if  = !m_busy && f_eff && (!ls_req_valid || m_last_ls);
        x_ls  = !m_busy && ls_req_valid && (!f_eff || !m_last_ls);
        chk("if_req_ready", 64'(if_req_ready), 64'(x_if));
        chk("ls_req_ready", 64'(ls_req_ready), 64'(x_ls));
        chk("ddr_req_valid", 64'(ddr_req_valid), 64'(m_busy && m_pend));
        if (m_busy && m_pend) begin
            chk("ddr_index", 64'(ddr_index), 64'(m_idx));
            chk("ddr_we", 64'(ddr_we), 64'(m_we));
            chk("ddr_wmask", 64'(ddr_wmask), 64'(m_wmask));
            if (m_we) chk("ddr_wdata", ddr_wdata, m_wdata);
        end
        chk("if_done", 64'(if_done), 64'(e_if_done));
        chk("ls_done", 64'(ls_done), 64'(e_ls_done));
        if (e_if_done) chk("if_rdata", if_rdata, e_if_rdata);
        if (e_ls_done) chk("ls_rdata", ls_rdata, e_ls_rdata);
        if (if_done) begin n_if_done_obs++; last_if_rdata = if_rdata; end
        if (ls_done) begin n_ls_done_obs++; last_ls_rdata = ls_rdata; end
        if (ddr_req_valid) n_ddr_vld++;
        if (ddr_req_valid && ddr_req_ready) n_ddr_hs++;

        e_if_done = 0; e_ls_done = 0;
        if (m_busy) begin
            if (redirect_valid && !m_owner_ls) m_killed = 1;
            if (m_pend) begin
                if (ddr_req_ready) begin m_pend = 0; cnt_wait = 0; end
                else cnt_cmd++;
            end else if (ddr_resp_valid) begin
                if (!m_owner_ls) begin
                    e_if_done  = !m_killed;
                    e_if_rdata = ddr_rdata;
                end else begin
                    e_ls_done  = 1;
                    e_ls_rdata = m_we ? 64'd0 : ddr_rdata;
                end
                m_busy = 0; m_killed = 0;
            end else cnt_wait++;
        end else if (x_if || x_ls) begin
            m_busy = 1; m_pend = 1; cnt_cmd = 0;
            m_owner_ls = x_ls; m_last_ls = x_ls;
            grant_log.push_back(x_ls ? 1 : 0);
            if (x_ls) begin
                m_idx = ls_req_addr[IDX_LSB +: IDX_W];
                m_we = ls_req_we; m_wdata = ls_req_wdata; m_wmask = ls_req_wmask;
            end else begin
                m_idx = if_req_addr[IDX_LSB +: IDX_W];
                m_we = 0; m_wdata = 64'd0; m_wmask = 8'hFF;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; model_reset();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic drain(string tag);
        for (int k = 0; k < 60 && m_busy; k++) cyc();
        chk(tag, 64'(m_busy), 64'd0);
        cyc(); cyc();
    endtask

    initial begin
        int sv_if, sv_ls, sv_hs, sv_vld;
        reset = 1'b1; model_reset();
        if_req_valid = 1'b1; if_req_addr = '0; redirect_valid = 0;
        ls_req_valid = 1'b1; ls_req_addr = '0; ls_req_we = 0; ls_req_wdata = '0; ls_req_wmask = '0;
        ddr_req_ready = 0; ddr_resp_valid = 0; ddr_rdata = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_if_ready", 64'(if_req_ready), 64'd0);
        chk("rst_ls_ready", 64'(ls_req_ready), 64'd0);
        chk("rst_ddr_valid", 64'(ddr_req_valid), 64'd0);
        chk("rst_outs", {ddr_index, ddr_we, ddr_wmask, if_done, ls_done}, 64'd0);
        chk("rst_rdata", if_rdata | ls_rdata | ddr_wdata, 64'd0);
        if_req_valid = 0; ls_req_valid = 0;
        reset = 1'b0;

        // Single fetch
        resp_lat = 3; rdata_val = 64'hDEAD;
        if_req_addr = 64'h8000_0010; if_req_valid = 1;
        cyc(); if_req_valid = 0;
        chk("t1_issue_next", 64'(ddr_req_valid), 64'd1);
        chk("t1_index", 64'(ddr_index), 64'h2);
        for (int k = 0; k < 20 && n_if_done_obs == 0; k++) cyc();
        chk("t1_rdata", last_if_rdata, 64'hDEAD);
        cyc(); cyc();
        chk("t1_done_once", 64'(n_if_done_obs), 64'd1);

        // Contention from reset
        do_reset();
        resp_lat = 0; grant_log.delete();
        if_req_valid = 1; if_req_addr = 64'h100; ls_req_valid = 1; ls_req_addr = 64'h2000;
        for (int k = 0; k < 60 && grant_log.size() < 4; k++) cyc();
        if_req_valid = 0; ls_req_valid = 0;
        chk("t2_grants", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() >= 4)
            chk("t2_order", {grant_log[0][7:0], grant_log[1][7:0], grant_log[2][7:0], grant_log[3][7:0]},
                64'h00_01_00_01);
        drain("t2_drain");

        // Redirect while fetch is in WAIT
        resp_lat = 4; sv_if = n_if_done_obs;
        if_req_addr = 64'h4440; if_req_valid = 1;
        cyc(); if_req_valid = 0;
        for (int k = 0; k < 20 && !(m_busy && !m_pend); k++) cyc();
        redirect_valid = 1; cyc(); redirect_valid = 0;
        drain("t3_drain");
        chk("t3_no_done", 64'(n_if_done_obs), 64'(sv_if));
        rdata_val = 64'hCAFE_F00D; resp_lat = 1;
        if_req_valid = 1; cyc(); if_req_valid = 0;
        drain("t3b_drain");
        chk("t3_next_fetch", 64'(n_if_done_obs), 64'(sv_if + 1));
        chk("t3_next_rdata", last_if_rdata, 64'hCAFE_F00D);

        // Backpressure: 5 cycles of ddr_req_ready=0
        hold_cyc = 5; sv_hs = n_ddr_hs; sv_vld = n_ddr_vld;
        ls_req_addr = 64'h1_2348; ls_req_we = 0; ls_req_wmask = 8'hFF; ls_req_valid = 1;
        cyc(); ls_req_valid = 0;
        drain("t4_drain");
        hold_cyc = 0;
        chk("t4_one_handshake", 64'(n_ddr_hs - sv_hs), 64'd1);
        chk("t4_valid_cycles", 64'(n_ddr_vld - sv_vld), 64'd6);

        // LS write
        sv_ls = n_ls_done_obs; rdata_val = 64'hFFFF_FFFF;
        ls_req_we = 1; ls_req_wdata = 64'h1122334455667788; ls_req_wmask = 8'h0F;
        ls_req_addr = 64'h80; ls_req_valid = 1;
        cyc(); ls_req_valid = 0; ls_req_we = 0;
        chk("t5_we", 64'(ddr_we), 64'd1);
        chk("t5_wdata", ddr_wdata, 64'h1122334455667788);
        chk("t5_wmask", 64'(ddr_wmask), 64'h0F);
        chk("t5_index", 64'(ddr_index), 64'h10);
        drain("t5_drain");
        chk("t5_done", 64'(n_ls_done_obs), 64'(sv_ls + 1));
        chk("t5_rdata_zero", last_ls_rdata, 64'd0);

        // Reset during WAIT, then a stray response
        resp_lat = 1000; sv_if = n_if_done_obs; sv_ls = n_ls_done_obs;
        if_req_addr = 64'h9990; if_req_valid = 1;
        cyc(); if_req_valid = 0;
        for (int k = 0; k < 20 && !(m_busy && !m_pend); k++) cyc();
        reset = 1'b1; model_reset(); if_req_valid = 1;
        #2;
        chk("t6_rst_ready", 64'(if_req_ready), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0; if_req_valid = 0;
        spur = 1; cyc(); cyc(); spur = 0;
        cyc();
        chk("t6_no_done", 64'(n_if_done_obs + n_ls_done_obs), 64'(sv_if + sv_ls));
        resp_lat = 1; if_req_valid = 1;
        #1;
        chk("t6_idle_ready", 64'(if_req_ready), 64'd1);
        cyc(); if_req_valid = 0;
        drain("t6_drain");

        // Randomized traffic
        ddr_mode = 1;
        for (int k = 0; k < 2000; k++) begin
            if_req_valid   = ($urandom_range(0, 2) != 0);
            if_req_addr    = {$urandom, $urandom};
            redirect_valid = ($urandom_range(0, 5) == 0);
            ls_req_valid   = ($urandom_range(0, 2) != 0);
            ls_req_addr    = {$urandom, $urandom};
            ls_req_we      = 1'($urandom_range(0, 1));
            ls_req_wdata   = {$urandom, $urandom};
            ls_req_wmask   = 8'($urandom);
            cyc();
        end
        if_req_valid = 0; ls_req_valid = 0; redirect_valid = 0;
        ddr_mode = 0; resp_lat = 0; hold_cyc = 0;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
